axi_decerr_responder: RTL and testbench

// Default AXI4 slave on the SoC crossbar; answers every request that matches no address rule.
// Any transaction outside the peripheral/DRAM map (Debug..DRAM rules) lands here and completes

---
 rtl/axi_decerr_responder.sv | 168 ++++++++++++++++
 tb/tb_axi_decerr_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_decerr_responder.sv
// Default AXI4 slave: completes every unmapped request with DECERR.
// Handles one outstanding write and one outstanding read on independent
// paths, and keeps a saturating handshake counter plus the last faulting
// address for debug.
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both high. Once this block raises b_valid_o
// or r_valid_o, it keeps it high with a constant payload until the matching
// ready is seen.
module axi_decerr_responder #(
  parameter int IdWidth   = 6,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData = 64'hBADC_AB1E_DEAD_BEEF,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic [AddrWidth-1:0] last_err_addr_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [IdWidth-1:0]   w_id_q;
  logic [IdWidth-1:0]   r_id_q;
  logic [7:0]           r_cnt_q;
  logic [CntWidth-1:0]  err_cnt_q;
  logic [AddrWidth-1:0] last_addr_q;

  logic                 aw_hs;
  logic                 ar_hs;
  logic [1:0]           hs_inc;
  logic [CntWidth:0]    cnt_sum;
  logic [CntWidth-1:0]  cnt_next;

  // Write FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        // Burst length is not tracked; w_last_i alone closes the burst.
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        if (r_ready_i && (r_cnt_q == 8'd0)) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;

  // Capture the write ID on AW acceptance; held through the B response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      w_id_q <= '0;
    else if (aw_hs) w_id_q <= aw_id_i;
  end

  // Capture read ID and remaining-beat count; count down on each accepted beat.
  // An 8-bit count loaded with 255 yields 256 beats without wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id_q  <= '0;
      r_cnt_q <= 8'd0;
    end else if (ar_hs) begin
      r_id_q  <= ar_id_i;
      r_cnt_q <= ar_len_i;
    end else if (r_valid_o && r_ready_i && (r_cnt_q != 8'd0)) begin
      r_cnt_q <= r_cnt_q - 8'd1;
    end
  end

  // Saturating add of 0, 1 or 2 handshakes this cycle.
  always_comb begin
    hs_inc   = {1'b0, aw_hs} + {1'b0, ar_hs};
    cnt_sum  = {1'b0, err_cnt_q} + {{(CntWidth-1){1'b0}}, hs_inc};
    cnt_next = cnt_sum[CntWidth] ? {CntWidth{1'b1}} : cnt_sum[CntWidth-1:0];
  end

  // Debug status: error count and last faulting address (AR wins a tie).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q   <= '0;
      last_addr_q <= '0;
    end else begin
      err_cnt_q <= cnt_next;
      if (ar_hs)      last_addr_q <= ar_addr_i;
      else if (aw_hs) last_addr_q <= aw_addr_i;
    end
  end

  assign b_id_o          = w_id_q;
  assign b_resp_o        = 2'b11;
  assign r_id_o          = r_id_q;
  assign r_resp_o        = 2'b11;
  assign r_data_o        = r_valid_o ? RespData : '0;
  assign r_last_o        = r_valid_o && (r_cnt_q == 8'd0);
  assign err_cnt_o       = err_cnt_q;
  assign last_err_addr_o = last_addr_q;

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Directed bench for axi_decerr_responder. A second instance with a 4-bit
// counter shares all inputs so counter saturation is reachable in a few
// dozen cycles.
module tb_axi_decerr_responder;

  localparam logic [63:0] RESP_DATA = 64'hBADC_AB1E_DEAD_BEEF;

  logic        clk;
  logic        rst;
  logic [5:0]  aw_id;
  logic [63:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;
  logic [5:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [5:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        ar_valid;
  logic        ar_ready;
  logic [5:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;
  logic [15:0] err_cnt;
  logic [63:0] last_addr;

  // Outputs of the small-counter instance.
  logic        s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_last, s_r_valid;
  logic [5:0]  s_b_id, s_r_id;
  logic [1:0]  s_b_resp, s_r_resp;
  logic [63:0] s_r_data, s_last_addr;
  logic [3:0]  s_err_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = 16'd0;

  axi_decerr_responder dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_valid_i(ar_valid),
    .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .err_cnt_o(err_cnt), .last_err_addr_o(last_addr)
  );

  axi_decerr_responder #(.CntWidth(4)) dut_small (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(s_aw_ready),
    .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(s_w_ready),
    .b_id_o(s_b_id), .b_resp_o(s_b_resp), .b_valid_o(s_b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_valid_i(ar_valid),
    .ar_ready_o(s_ar_ready),
    .r_id_o(s_r_id), .r_data_o(s_r_data), .r_resp_o(s_r_resp), .r_last_o(s_r_last),
    .r_valid_o(s_r_valid), .r_ready_i(r_ready),
    .err_cnt_o(s_err_cnt), .last_err_addr_o(s_last_addr)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs are driven and outputs
  // sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue AW and AR (len 0) together, then complete both.
  task automatic drive_pair(input logic [63:0] wa, input logic [63:0] ra);
    aw_valid = 1'b1; aw_addr = wa; aw_id = 6'd1;
    ar_valid = 1'b1; ar_addr = ra; ar_id = 6'd2; ar_len = 8'd0;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    w_valid = 1'b1; w_last = 1'b1; r_ready = 1'b1; b_ready = 1'b1;
    tick();
    w_valid = 1'b0;
    tick();
    w_last = 1'b0; r_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aw_id = '0; aw_addr = '0; aw_valid = 1'b0; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0;
    r_ready = 1'b0;
    tick(); tick();
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: aw_ready=%b ar_ready=%b expected 1 1", aw_ready, ar_ready);
    end
    checks++;
    if (w_ready !== 1'b0 || b_valid !== 1'b0 || r_valid !== 1'b0 || r_last !== 1'b0) begin
      errors++; $display("FAIL reset_valids: w_ready=%b b_valid=%b r_valid=%b r_last=%b expected 0",
                         w_ready, b_valid, r_valid, r_last);
    end
    checks++;
    if (b_id !== 6'd0 || r_id !== 6'd0 || err_cnt !== 16'd0 || last_addr !== 64'd0) begin
      errors++; $display("FAIL reset_status: b_id=%h r_id=%h err_cnt=%h last_addr=%h expected 0",
                         b_id, r_id, err_cnt, last_addr);
    end
    rst = 1'b0;
    exp_cnt = 16'd0;
    tick();
  endtask

  task automatic test_write();
    aw_valid = 1'b1; aw_id = 6'd5; aw_addr = 64'h6000_0000;
    tick();
    aw_valid = 1'b0; aw_addr = '0;
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (aw_ready !== 1'b0 || err_cnt !== exp_cnt || last_addr !== 64'h6000_0000) begin
      errors++; $display("FAIL write_aw: aw_ready=%b err_cnt=%h last_addr=%h expected 0 %h 60000000",
                         aw_ready, err_cnt, last_addr, exp_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1; w_last = (i == 3);
      checks++;
      if (w_ready !== 1'b1 || b_valid !== 1'b0) begin
        errors++; $display("FAIL write_beat%0d: w_ready=%b b_valid=%b expected 1 0", i, w_ready, b_valid);
      end
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    checks++;
    if (b_valid !== 1'b1 || b_id !== 6'd5 || b_resp !== 2'b11 || w_ready !== 1'b0) begin
      errors++; $display("FAIL write_b: b_valid=%b b_id=%0d b_resp=%b w_ready=%b expected 1 5 11 0",
                         b_valid, b_id, b_resp, w_ready);
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    checks++;
    if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
      errors++; $display("FAIL write_done: b_valid=%b aw_ready=%b expected 0 1", b_valid, aw_ready);
    end
  endtask

  task automatic test_read_single();
    ar_valid = 1'b1; ar_id = 6'd3; ar_len = 8'd0; ar_addr = 64'h7000; r_ready = 1'b1;
    tick();
    ar_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (r_valid !== 1'b1 || r_last !== 1'b1 || r_resp !== 2'b11 || r_data !== RESP_DATA ||
        r_id !== 6'd3 || ar_ready !== 1'b0) begin
      errors++; $display("FAIL read_single_beat: valid=%b last=%b resp=%b data=%h id=%0d ar_ready=%b",
                         r_valid, r_last, r_resp, r_data, r_id, ar_ready);
    end
    tick();
    r_ready = 1'b0;
    checks++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
      errors++; $display("FAIL read_single_done: r_valid=%b ar_ready=%b expected 0 1", r_valid, ar_ready);
    end
    checks++;
    if (err_cnt !== exp_cnt || last_addr !== 64'h7000) begin
      errors++; $display("FAIL read_single_status: err_cnt=%h last_addr=%h expected %h 7000",
                         err_cnt, last_addr, exp_cnt);
    end
  endtask

  task automatic test_read_burst();
    int beats = 0;
    int cyc = 0;
    logic rr;
    ar_valid = 1'b1; ar_id = 6'd9; ar_len = 8'd255; ar_addr = 64'h8000;
    tick();
    ar_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    while (beats < 256 && cyc < 3000) begin
      rr = 1'($urandom_range(0, 1));
      r_ready = rr;
      checks++;
      if (r_valid !== 1'b1 || r_last !== (beats == 255) || r_id !== 6'd9 ||
          r_data !== RESP_DATA || r_resp !== 2'b11) begin
        errors++; $display("FAIL burst_beat%0d: valid=%b last=%b id=%0d data=%h resp=%b",
                           beats, r_valid, r_last, r_id, r_data, r_resp);
      end
      if (r_valid && rr) beats++;
      tick();
      cyc++;
    end
    r_ready = 1'b0;
    checks++;
    if (beats !== 256) begin
      errors++; $display("FAIL burst_count: beats=%0d expected 256 (cycle budget %0d)", beats, cyc);
    end
    checks++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
      errors++; $display("FAIL burst_done: r_valid=%b ar_ready=%b expected 0 1", r_valid, ar_ready);
    end
  endtask

  task automatic test_simultaneous();
    aw_valid = 1'b1; aw_id = 6'd1; aw_addr = 64'h100;
    ar_valid = 1'b1; ar_id = 6'd2; ar_addr = 64'h200; ar_len = 8'd1;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd2;
    checks++;
    if (err_cnt !== exp_cnt || last_addr !== 64'h200) begin
      errors++; $display("FAIL simul_status: err_cnt=%h last_addr=%h expected %h 200",
                         err_cnt, last_addr, exp_cnt);
    end
    checks++;
    if (r_valid !== 1'b1 || r_last !== 1'b0 || w_ready !== 1'b1) begin
      errors++; $display("FAIL simul_first: r_valid=%b r_last=%b w_ready=%b expected 1 0 1",
                         r_valid, r_last, w_ready);
    end
    w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    checks++;
    if (b_valid !== 1'b1 || b_id !== 6'd1 || r_valid !== 1'b1 || r_last !== 1'b1 || r_id !== 6'd2) begin
      errors++; $display("FAIL simul_second: b_valid=%b b_id=%0d r_valid=%b r_last=%b r_id=%0d",
                         b_valid, b_id, r_valid, r_last, r_id);
    end
    tick();
    b_ready = 1'b0; r_ready = 1'b0;
    checks++;
    if (b_valid !== 1'b0 || r_valid !== 1'b0 || aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
      errors++; $display("FAIL simul_done: b_valid=%b r_valid=%b aw_ready=%b ar_ready=%b",
                         b_valid, r_valid, aw_ready, ar_ready);
    end
  endtask

  task automatic test_stall();
    w_valid = 1'b1; w_last = 1'b1;
    tick(); tick();
    checks++;
    if (w_ready !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("FAIL stall_early_w: w_ready=%b b_valid=%b expected 0 0", w_ready, b_valid);
    end
    aw_valid = 1'b1; aw_id = 6'd7; aw_addr = 64'h4000;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    aw_addr = 64'h999; aw_id = 6'd11;
    checks++;
    if (w_ready !== 1'b1) begin
      errors++; $display("FAIL stall_w_open: w_ready=%b expected 1", w_ready);
    end
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (b_valid !== 1'b1 || b_id !== 6'd7 || b_resp !== 2'b11 || aw_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: b_valid=%b b_id=%0d b_resp=%b aw_ready=%b",
                           i, b_valid, b_id, b_resp, aw_ready);
      end
      tick();
    end
    aw_valid = 1'b0;
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    checks++;
    if (b_valid !== 1'b0 || err_cnt !== exp_cnt || last_addr !== 64'h4000) begin
      errors++; $display("FAIL stall_done: b_valid=%b err_cnt=%h last_addr=%h expected 0 %h 4000",
                         b_valid, err_cnt, last_addr, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    tick();
    exp_cnt = 16'd0;
    for (int i = 0; i < 7; i++) begin
      drive_pair(64'h100 + 64'(i), 64'h200 + 64'(i));
      exp_cnt = exp_cnt + 16'd2;
    end
    checks++;
    if (err_cnt !== 16'd14 || s_err_cnt !== 4'hE) begin
      errors++; $display("FAIL sat_pre: err_cnt=%h small=%h expected 000e e", err_cnt, s_err_cnt);
    end
    drive_pair(64'h300, 64'h400);
    exp_cnt = exp_cnt + 16'd2;
    checks++;
    if (err_cnt !== exp_cnt || s_err_cnt !== 4'hF || last_addr !== 64'h400) begin
      errors++; $display("FAIL sat_hit: err_cnt=%h small=%h last_addr=%h expected %h f 400",
                         err_cnt, s_err_cnt, last_addr, exp_cnt);
    end
    drive_pair(64'h500, 64'h600);
    exp_cnt = exp_cnt + 16'd2;
    checks++;
    if (err_cnt !== exp_cnt || s_err_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_hold: err_cnt=%h small=%h expected %h f", err_cnt, s_err_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    ar_valid = 1'b1; ar_id = 6'd4; ar_len = 8'd10; ar_addr = 64'hA000;
    tick();
    ar_valid = 1'b0; r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    checks++;
    if (r_valid !== 1'b1 || ar_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_pre: r_valid=%b ar_ready=%b expected 1 0", r_valid, ar_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (r_valid !== 1'b0 || r_last !== 1'b0 || ar_ready !== 1'b1 || err_cnt !== 16'd0 ||
        last_addr !== 64'd0) begin
      errors++; $display("FAIL midrst_async: r_valid=%b r_last=%b ar_ready=%b err_cnt=%h last_addr=%h",
                         r_valid, r_last, ar_ready, err_cnt, last_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1 || aw_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_after: r_valid=%b ar_ready=%b aw_ready=%b expected 0 1 1",
                         r_valid, ar_ready, aw_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_single();
    test_read_burst();
    test_simultaneous();
    test_stall();
    test_saturation();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
